// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline sequencing controller.
// Branch-type and FSM state encodings plus the branch-taken decode.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      BR_BEQ  = 2'b00,
      BR_BNE  = 2'b01,
      BR_BLEZ = 2'b10,
      BR_BGTZ = 2'b11
   } br_type_e;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // nz/sign describe rs-rt for BEQ/BNE and rs alone for BLEZ/BGTZ
   function automatic logic branch_taken(input br_type_e br_type, input logic nz, input logic sign);
      logic taken;
      case (br_type)
         BR_BEQ:  taken = ~nz;
         BR_BNE:  taken = nz;
         BR_BLEZ: taken = sign | ~nz;
         BR_BGTZ: taken = ~sign & nz;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // count register: holds at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= {CNT_W{1'b0}};
      end else if (clr) begin
         count <= {CNT_W{1'b0}};
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_ONE;
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch resolution and load-use stall sequencing for the 5-stage pipeline,
// with saturating performance counters for branches, taken branches and bubbles.
module branch_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int LOAD_STALL_CYC = 1,
   parameter int CNT_W          = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ex_branch_i,
   input  logic [1:0]       ex_brtype_i,
   input  logic             ex_nz_i,
   input  logic             ex_sign_i,
   input  logic             id_ex_memread_i,
   input  logic [4:0]       id_ex_rt_i,
   input  logic [4:0]       if_id_rs_i,
   input  logic [4:0]       if_id_rt_i,
   input  logic             if_id_uses_rt_i,
   input  logic             perf_clr_i,
   output logic             pc_src_o,
   output logic             pc_write_o,
   output logic             if_id_write_o,
   output logic             if_id_flush_o,
   output logic             id_ex_flush_o,
   output logic [CNT_W-1:0] perf_br_o,
   output logic [CNT_W-1:0] perf_taken_o,
   output logic [CNT_W-1:0] perf_stall_o
);

   // first bubble is issued from RUN, the remainder are counted down in STALL
   localparam logic [2:0] STALL_INIT  = 3'(LOAD_STALL_CYC - 32'sd1);
   localparam logic       MULTI_STALL = (LOAD_STALL_CYC > 32'sd1);

   state_e     state;
   state_e     next_state;
   logic [2:0] bcnt;
   logic [2:0] next_bcnt;
   logic       taken;
   logic       hazard;
   logic       br_inc;
   logic       taken_inc;
   logic       stall_inc;

   assign taken  = ex_branch_i & branch_taken(br_type_e'(ex_brtype_i), ex_nz_i, ex_sign_i);
   assign hazard = id_ex_memread_i & (id_ex_rt_i != REG_ZERO) &
                   ((id_ex_rt_i == if_id_rs_i) | (if_id_uses_rt_i & (id_ex_rt_i == if_id_rt_i)));

   // state and bubble counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_RUN;
         bcnt  <= 3'd0;
      end else begin
         state <= next_state;
         bcnt  <= next_bcnt;
      end
   end

   // next-state logic; a taken branch wins over a hazard since ID is wrong-path
   always_comb begin
      next_state = ST_RUN;
      next_bcnt  = 3'd0;
      case (state)
         ST_RUN: begin
            if (!taken && hazard && MULTI_STALL) begin
               next_state = ST_STALL;
               next_bcnt  = STALL_INIT;
            end else begin
               next_state = ST_RUN;
               next_bcnt  = 3'd0;
            end
         end
         ST_STALL: begin
            if (bcnt <= 3'd1) begin
               next_state = ST_RUN;
               next_bcnt  = 3'd0;
            end else begin
               next_state = ST_STALL;
               next_bcnt  = bcnt - 3'd1;
            end
         end
         default: begin
            next_state = ST_RUN;
            next_bcnt  = 3'd0;
         end
      endcase
   end

   // control outputs, zero-cycle response to the EX/ID inputs
   always_comb begin
      pc_src_o      = 1'b0;
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      if (rst_i) begin
         pc_write_o    = 1'b0;
         if_id_flush_o = 1'b1;
      end else begin
         case (state)
            ST_RUN: begin
               if (taken) begin
                  pc_src_o      = 1'b1;
                  pc_write_o    = 1'b1;
                  if_id_write_o = 1'b1;
                  if_id_flush_o = 1'b1;
                  id_ex_flush_o = 1'b1;
               end else if (hazard) begin
                  if_id_flush_o = 1'b0;
                  id_ex_flush_o = 1'b1;
               end else begin
                  pc_write_o    = 1'b1;
                  if_id_write_o = 1'b1;
                  if_id_flush_o = 1'b0;
                  id_ex_flush_o = 1'b0;
               end
            end
            ST_STALL: begin
               if_id_flush_o = 1'b0;
               id_ex_flush_o = 1'b1;
            end
            default: begin
               if_id_flush_o = 1'b1;
               id_ex_flush_o = 1'b1;
            end
         endcase
      end
   end

   assign br_inc    = (state == ST_RUN) & ex_branch_i;
   assign taken_inc = (state == ST_RUN) & taken;
   assign stall_inc = ((state == ST_RUN) & ~taken & hazard) | (state == ST_STALL);

   sat_counter #(.CNT_W(CNT_W)) u_cnt_br (
      .clk   (clk_i),
      .rst   (rst_i),
      .clr   (perf_clr_i),
      .inc   (br_inc),
      .count (perf_br_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cnt_taken (
      .clk   (clk_i),
      .rst   (rst_i),
      .clr   (perf_clr_i),
      .inc   (taken_inc),
      .count (perf_taken_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cnt_stall (
      .clk   (clk_i),
      .rst   (rst_i),
      .clr   (perf_clr_i),
      .inc   (stall_inc),
      .count (perf_stall_o)
   );

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: instance a has two-cycle load stalls and
// 32-bit counters, instance b has single-cycle stalls and 4-bit counters.
module tb_branch_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       ex_branch;
   logic [1:0] ex_brtype;
   logic       ex_nz;
   logic       ex_sign;
   logic       memread;
   logic [4:0] ld_rt;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       uses_rt;
   logic       perf_clr;

   logic        a_pc_src, a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_flush;
   logic [31:0] a_br, a_taken, a_stall;
   logic        b_pc_src, b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush;
   logic [3:0]  b_br, b_taken, b_stall;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   branch_hazard_ctrl #(.LOAD_STALL_CYC(2), .CNT_W(32)) u_a (
      .clk_i(clk), .rst_i(rst), .ex_branch_i(ex_branch), .ex_brtype_i(ex_brtype),
      .ex_nz_i(ex_nz), .ex_sign_i(ex_sign), .id_ex_memread_i(memread), .id_ex_rt_i(ld_rt),
      .if_id_rs_i(id_rs), .if_id_rt_i(id_rt), .if_id_uses_rt_i(uses_rt), .perf_clr_i(perf_clr),
      .pc_src_o(a_pc_src), .pc_write_o(a_pc_write), .if_id_write_o(a_if_id_write),
      .if_id_flush_o(a_if_id_flush), .id_ex_flush_o(a_id_ex_flush),
      .perf_br_o(a_br), .perf_taken_o(a_taken), .perf_stall_o(a_stall)
   );

   branch_hazard_ctrl #(.LOAD_STALL_CYC(1), .CNT_W(4)) u_b (
      .clk_i(clk), .rst_i(rst), .ex_branch_i(ex_branch), .ex_brtype_i(ex_brtype),
      .ex_nz_i(ex_nz), .ex_sign_i(ex_sign), .id_ex_memread_i(memread), .id_ex_rt_i(ld_rt),
      .if_id_rs_i(id_rs), .if_id_rt_i(id_rt), .if_id_uses_rt_i(uses_rt), .perf_clr_i(perf_clr),
      .pc_src_o(b_pc_src), .pc_write_o(b_pc_write), .if_id_write_o(b_if_id_write),
      .if_id_flush_o(b_if_id_flush), .id_ex_flush_o(b_id_ex_flush),
      .perf_br_o(b_br), .perf_taken_o(b_taken), .perf_stall_o(b_stall)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      ex_branch = 1'b0; ex_brtype = 2'b00; ex_nz = 1'b0; ex_sign = 1'b0;
      memread = 1'b0; ld_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; uses_rt = 1'b0;
      perf_clr = 1'b0;
   endtask

   // advance one clock, leave inputs settled away from the edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic branch(input logic [1:0] t, input logic nz, input logic sg);
      ex_branch = 1'b1; ex_brtype = t; ex_nz = nz; ex_sign = sg;
   endtask

   task automatic load_use(input logic [4:0] rt_ld, input logic [4:0] rs, input logic [4:0] rt, input logic use_rt);
      memread = 1'b1; ld_rt = rt_ld; id_rs = rs; id_rt = rt; uses_rt = use_rt;
   endtask

   task automatic br_vec(input string tag, input logic [1:0] t, input logic nz, input logic sg, input logic exp);
      idle();
      branch(t, nz, sg);
      #1;
      check_eq(tag, a_pc_src, exp);
      check_eq({tag, "_flush"}, a_id_ex_flush, exp);
      tick();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      tick();
      #1;
      check_eq("rst_pc_write", a_pc_write, 1'b0);
      check_eq("rst_if_id_write", a_if_id_write, 1'b0);
      check_eq("rst_if_id_flush", a_if_id_flush, 1'b1);
      check_eq("rst_id_ex_flush", a_id_ex_flush, 1'b1);
      check_eq("rst_pc_src", a_pc_src, 1'b0);
      tick();
      check_eq("rst_br", a_br, 32'd0);
      check_eq("rst_stall", a_stall, 32'd0);
      rst = 1'b0;
      #1;
      check_eq("run_pc_write", a_pc_write, 1'b1);
      check_eq("run_if_id_flush", a_if_id_flush, 1'b0);
      check_eq("run_id_ex_flush", a_id_ex_flush, 1'b0);
      tick();

      // BEQ taken
      branch(2'b00, 1'b0, 1'b0);
      #1;
      check_eq("beq_pc_src", a_pc_src, 1'b1);
      check_eq("beq_if_id_flush", a_if_id_flush, 1'b1);
      check_eq("beq_id_ex_flush", a_id_ex_flush, 1'b1);
      check_eq("beq_pc_write", a_pc_write, 1'b1);
      tick();
      idle();
      check_eq("beq_perf_br", a_br, 32'd1);
      check_eq("beq_perf_taken", a_taken, 32'd1);

      // BNE / BLEZ / BGTZ truth table
      br_vec("bne_00", 2'b01, 1'b0, 1'b0, 1'b0);
      br_vec("bne_10", 2'b01, 1'b1, 1'b0, 1'b1);
      br_vec("bne_11", 2'b01, 1'b1, 1'b1, 1'b1);
      br_vec("blez_00", 2'b10, 1'b0, 1'b0, 1'b1);
      br_vec("blez_10", 2'b10, 1'b1, 1'b0, 1'b0);
      br_vec("blez_11", 2'b10, 1'b1, 1'b1, 1'b1);
      br_vec("bgtz_00", 2'b11, 1'b0, 1'b0, 1'b0);
      br_vec("bgtz_10", 2'b11, 1'b1, 1'b0, 1'b1);
      br_vec("bgtz_11", 2'b11, 1'b1, 1'b1, 1'b0);
      idle();
      check_eq("tbl_perf_br", a_br, 32'd10);
      check_eq("tbl_perf_taken", a_taken, 32'd6);

      // load-use on rs: two bubbles on a, one on b; STALL ignores a branch
      load_use(5'd5, 5'd5, 5'd0, 1'b0);
      #1;
      check_eq("hz_a_pc_write0", a_pc_write, 1'b0);
      check_eq("hz_a_if_id_write0", a_if_id_write, 1'b0);
      check_eq("hz_a_id_ex_flush0", a_id_ex_flush, 1'b1);
      check_eq("hz_a_if_id_flush0", a_if_id_flush, 1'b0);
      check_eq("hz_b_pc_write0", b_pc_write, 1'b0);
      tick();
      idle();
      branch(2'b00, 1'b0, 1'b0);
      #1;
      check_eq("hz_a_pc_write1", a_pc_write, 1'b0);
      check_eq("hz_a_pc_src1", a_pc_src, 1'b0);
      check_eq("hz_b_pc_write1", b_pc_write, 1'b1);
      tick();
      idle();
      #1;
      check_eq("hz_a_pc_write2", a_pc_write, 1'b1);
      check_eq("hz_a_perf_stall", a_stall, 32'd2);
      check_eq("hz_b_perf_stall", b_stall, 32'd1);
      check_eq("hz_a_br_ignored", a_br, 32'd10);
      check_eq("hz_b_br", b_br, 32'd11);

      // loads to r0 never stall
      load_use(5'd0, 5'd0, 5'd0, 1'b1);
      #1;
      check_eq("r0_pc_write", a_pc_write, 1'b1);
      // rt match only counts when rt is a source
      load_use(5'd7, 5'd3, 5'd7, 1'b0);
      #1;
      check_eq("rt_unused_pc_write", a_pc_write, 1'b1);
      load_use(5'd7, 5'd3, 5'd7, 1'b1);
      #1;
      check_eq("rt_used_pc_write", a_pc_write, 1'b0);
      tick();
      idle();
      tick();
      check_eq("rt_a_perf_stall", a_stall, 32'd4);
      check_eq("rt_b_perf_stall", b_stall, 32'd2);

      // taken branch overrides a simultaneous hazard
      branch(2'b00, 1'b0, 1'b0);
      load_use(5'd5, 5'd5, 5'd0, 1'b0);
      #1;
      check_eq("ovr_pc_write", a_pc_write, 1'b1);
      check_eq("ovr_pc_src", a_pc_src, 1'b1);
      check_eq("ovr_id_ex_flush", a_id_ex_flush, 1'b1);
      tick();
      idle();
      check_eq("ovr_perf_stall", a_stall, 32'd4);
      check_eq("ovr_perf_taken", a_taken, 32'd7);

      // reset in the first STALL cycle
      load_use(5'd9, 5'd9, 5'd0, 1'b0);
      tick();
      idle();
      rst = 1'b1;
      #1;
      check_eq("rst_stall_if_id_flush", a_if_id_flush, 1'b1);
      check_eq("rst_stall_pc_write", a_pc_write, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      check_eq("post_rst_stall", a_stall, 32'd0);
      check_eq("post_rst_br", a_br, 32'd0);
      check_eq("post_rst_pc_write", a_pc_write, 1'b1);
      load_use(5'd9, 5'd9, 5'd0, 1'b0);
      #1;
      check_eq("fresh_pc_write0", a_pc_write, 1'b0);
      tick();
      idle();
      #1;
      check_eq("fresh_pc_write1", a_pc_write, 1'b0);
      tick();
      check_eq("fresh_pc_write2", a_pc_write, 1'b1);
      check_eq("fresh_perf_stall", a_stall, 32'd2);

      // saturation of the 4-bit counters, then clear beats increment
      for (int i = 0; i < 20; i++) begin
         branch(2'b00, 1'b0, 1'b0);
         tick();
      end
      check_eq("sat_b_taken", b_taken, 32'd15);
      check_eq("sat_b_br", b_br, 32'd15);
      check_eq("sat_a_taken", a_taken, 32'd20);
      perf_clr = 1'b1;
      tick();
      idle();
      check_eq("clr_b_taken", b_taken, 32'd0);
      check_eq("clr_a_taken", a_taken, 32'd0);
      check_eq("clr_a_br", a_br, 32'd0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
